// File: rtl/bepu_pkg.sv
// Shared constants for the BEPU LED / seven-segment peripheral:
// default chip-select bit positions, the blank glyph and the hex font.
package bepu_pkg;

    localparam int LED_SEL_BIT_DEFAULT = 1;
    localparam int SEG_SEL_BIT_DEFAULT = 2;

    // Cathodes {dp,g,f,e,d,c,b,a}, active-low; all high turns every segment off.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low hex glyphs 0..F with the decimal point off.
    localparam logic [7:0] SEG_FONT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/bepu_led_segment_if.sv
// Bus from the front-end processing unit into the back-end peripherals.
// Handshake: bepu_w qualifies a write in the cycle it is high; there is no
// ready/backpressure, so every qualified write is accepted at that clock edge.
// bepu_select is one-hot and already decoded from bepu_addr upstream.
interface bepu_led_segment_if;
    logic [31:0] bepu_select;
    logic        bepu_w;
    logic [31:0] bepu_data;
    logic [31:0] bepu_addr;

    modport master (output bepu_select, output bepu_w, output bepu_data, output bepu_addr);
    modport slave  (input  bepu_select, input  bepu_w, input  bepu_data, input  bepu_addr);
endinterface

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low cathode lookup, with a blank override.
module seg7_decode
    import bepu_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [7:0] cat
);

    // Blank wins over the glyph so suppressed leading zeros show nothing.
    always_comb begin
        cat = SEG_FONT[nibble];
        if (blank) begin
            cat = SEG_BLANK;
        end
    end

endmodule

// File: rtl/bepu_led_segment.sv
// LED register plus 8-digit multiplexed hex display on the BEPU bus.
// Optional build macro: BEPU_ZERO_BLANK_EN enables leading-zero blanking
// (digit 0 is always shown); without it every digit shows its hex glyph.
module bepu_led_segment
    import bepu_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int LED_SEL_BIT = LED_SEL_BIT_DEFAULT,
    parameter int SEG_SEL_BIT = SEG_SEL_BIT_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    bepu_led_segment_if.slave          bus,
    output logic [15:0]                led,
    output logic [7:0]                 seg_an,
    output logic [7:0]                 seg_cat
);

    localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);

    logic [31:0] seg_val;
    logic [15:0] cnt;
    logic [2:0]  dig;
    logic [3:0]  cur_nibble;
    logic        cur_blank;
    logic [7:0]  cat_next;

    // Address is pre-decoded into select upstream; the high select bits belong
    // to other peripherals. Folded here so they are visibly consumed.
    logic unused_bus;
    assign unused_bus = ^{bus.bepu_addr, bus.bepu_select};

    // Bus write decode: each register latches when its select bit and the strobe are high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led     <= '0;
            seg_val <= '0;
        end else if (bus.bepu_w) begin
            if (bus.bepu_select[LED_SEL_BIT]) begin
                led <= bus.bepu_data[15:0];
            end
            if (bus.bepu_select[SEG_SEL_BIT]) begin
                seg_val <= bus.bepu_data;
            end
        end
    end

    // Scan timing: dig advances once per SCAN_DIV cycles and wraps 7 -> 0 naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            dig <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            dig <= dig + 3'd1;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // Select the nibble for the lit digit and decide whether it is a leading zero.
    always_comb begin
        cur_nibble = seg_val[{dig, 2'b00} +: 4];
        cur_blank  = 1'b0;
`ifdef BEPU_ZERO_BLANK_EN
        if (dig != 3'd0 && (seg_val >> {dig, 2'b00}) == 32'd0) begin
            cur_blank = 1'b1;
        end
`endif
    end

    seg7_decode u_decode (
        .nibble (cur_nibble),
        .blank  (cur_blank),
        .cat    (cat_next)
    );

    // Output registers: one cycle behind dig, so each digit is lit for a full period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_an  <= 8'hFE;
            seg_cat <= SEG_FONT[0];
        end else begin
            seg_an  <= ~(8'b1 << dig);
            seg_cat <= cat_next;
        end
    end

endmodule

// File: tb/tb_bepu_led_segment.sv
// Directed bench for bepu_led_segment with a short scan period.
module tb_bepu_led_segment;

    localparam int SCAN_DIV = 4;

    logic        clk;
    logic        rst;
    logic [15:0] led;
    logic [7:0]  seg_an;
    logic [7:0]  seg_cat;

    int vec_cnt = 0;
    int err_cnt = 0;

    bepu_led_segment_if bus ();

    bepu_led_segment #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .led     (led),
        .seg_an  (seg_an),
        .seg_cat (seg_cat)
    );

    // Clock: posedges at 5, 15, ...; inputs driven and outputs sampled on negedges.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // One-cycle bus write, returns at the negedge after the capturing edge.
    task automatic bus_write(input logic [31:0] sel, input logic [31:0] data);
        bus.bepu_select = sel;
        bus.bepu_w      = 1'b1;
        bus.bepu_data   = data;
        @(negedge clk);
        bus.bepu_w      = 1'b0;
        bus.bepu_select = 32'h0;
    endtask

    // Wait (bounded) until digit k is lit, then compare its cathodes.
    task automatic check_digit(input string tag, input int k, input logic [7:0] exp_cat);
        logic [7:0] an_want;
        bit found;
        an_want = ~(8'b1 << k);
        found = 0;
        @(negedge clk);
        for (int i = 0; i < 40 && !found; i++) begin
            if (seg_an == an_want) found = 1;
            else @(negedge clk);
        end
        if (!found) check({tag, "_timeout"}, {24'h0, seg_an}, {24'h0, an_want});
        else        check(tag, {24'h0, seg_cat}, {24'h0, exp_cat});
    endtask

    logic [7:0] an_tab  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] cat_tab [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
`ifdef BEPU_ZERO_BLANK_EN
    localparam logic [7:0] LEAD_ZERO = 8'hFF;
`else
    localparam logic [7:0] LEAD_ZERO = 8'hC0;
`endif

    initial begin
        int d;
        logic [7:0] cat_want;
        rst = 1'b0;
        bus.bepu_select = 32'h0;
        bus.bepu_w      = 1'b0;
        bus.bepu_data   = 32'h0;
        bus.bepu_addr   = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("rst_led",  {16'h0, led},     32'h0);
        check("rst_an",   {24'h0, seg_an},  32'hFE);
        check("rst_cat",  {24'h0, seg_cat}, 32'hC0);

        // LED write, then an unstrobed write that must be ignored.
        rst = 1'b1;
        @(negedge clk);
        bus_write(32'h2, 32'hABCD1234);
        check("led_write", {16'h0, led}, 32'h1234);
        bus.bepu_select = 32'h2;
        bus.bepu_w      = 1'b0;
        bus.bepu_data   = 32'h0000FFFF;
        @(negedge clk);
        bus.bepu_select = 32'h0;
        check("led_no_w", {16'h0, led}, 32'h1234);

        // Let the scan move off digit 0, then reset asynchronously mid-cycle.
        bus_write(32'h4, 32'h87654321);
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_led", {16'h0, led},     32'h0);
        check("midrst_an",  {24'h0, seg_an},  32'hFE);
        check("midrst_cat", {24'h0, seg_cat}, 32'hC0);
        @(negedge clk);
        @(negedge clk);

        // Release with a segment write in the first cycle; the first registered
        // frame still uses the cleared seg_val (glyph 0), later ones the new value.
        rst = 1'b1;
        bus.bepu_select = 32'h4;
        bus.bepu_w      = 1'b1;
        bus.bepu_data   = 32'h12345678;
        for (int n = 1; n <= 36; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus.bepu_w      = 1'b0;
                bus.bepu_select = 32'h0;
            end
            d = ((n - 1) / SCAN_DIV) % 8;
            cat_want = (n == 1) ? 8'hC0 : cat_tab[d];
            check($sformatf("scan_an_%0d", n),  {24'h0, seg_an},  {24'h0, an_tab[d]});
            check($sformatf("scan_cat_%0d", n), {24'h0, seg_cat}, {24'h0, cat_want});
        end

        // Dual select writes both registers.
        bus_write(32'h6, 32'h0000BEEF);
        check("dual_led", {16'h0, led}, 32'hBEEF);
        check_digit("dual_d0", 0, 8'h8E);
        check_digit("dual_d1", 1, 8'h86);
        check_digit("dual_d3", 3, 8'h83);
        check_digit("dual_d4", 4, LEAD_ZERO);

        // A select bit that belongs to neither register changes nothing.
        bus_write(32'h1, 32'h12345678);
        check("other_sel_led", {16'h0, led}, 32'hBEEF);
        check_digit("other_sel_d0", 0, 8'h8E);
        check_digit("other_sel_d2", 2, 8'h86);

        // Leading-zero handling; interior zero digit 1 is always shown.
        bus_write(32'h4, 32'h00000A05);
        check_digit("blank_d0", 0, 8'h92);
        check_digit("blank_d1", 1, 8'hC0);
        check_digit("blank_d2", 2, 8'h88);
        for (int k = 3; k < 8; k++) begin
            check_digit($sformatf("blank_d%0d", k), k, LEAD_ZERO);
        end
        check("blank_led", {16'h0, led}, 32'hBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/bepu_led_segment.md
# bepu_led_segment

Back-end peripheral stage fed directly by the front-end processing unit's bus outputs (select, write strobe, data, address). Decodes one-hot chip-select writes into a 16-bit LED register and a 32-bit seven-segment value register. Continuously time-multiplexes the 32-bit value as eight hex digits onto a common-anode, active-low 8-digit display.

## Interface
- SCAN_DIV, 50000: clock cycles each digit stays lit; legal range 2..65535.
- LED_SEL_BIT, 1: select bit that addresses the LED register.
- SEG_SEL_BIT, 2: select bit that addresses the segment register.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- bepu_select  in  32  one-hot chip select from the bus controller.
- bepu_w  in  1  write strobe; 1 = write this cycle.
- bepu_data  in  32  write data.
- bepu_addr  in  32  bus address; not decoded here, since the bus controller has already decoded it into select.
- led  out  16  LED register, active-high.
- seg_an  out  8  digit anodes, active-low one-hot; bit 0 = rightmost digit.
- seg_cat  out  8  cathodes {dp,g,f,e,d,c,b,a}, active-low.

## Operation
- LED write: bepu_w=1 and bepu_select[LED_SEL_BIT]=1 latches led <= bepu_data[15:0].
- Segment write: bepu_w=1 and bepu_select[SEG_SEL_BIT]=1 latches seg_val <= bepu_data.
- Both select bits set in the same cycle: both registers write. All other select bits are ignored. bepu_w=0 writes nothing.
- Scan counter cnt runs 0..SCAN_DIV-1 and wraps to 0.
- Digit index dig (3 bits) increments on the cycle cnt==SCAN_DIV-1; it wraps from 7 to 0.
- Nibble shown for digit k = seg_val[4k+3:4k]. Hex font (active-low, dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- seg_an and seg_cat are registered every cycle from the current dig and seg_val.

## Timing
- Reset values:
  - led=0, seg_val=0, cnt=0, dig=0.
  - seg_an=8'hFE, seg_cat=8'hC0.
- Reset is asynchronous on assertion. Deassertion is synchronised externally.
- Reset mid-scan returns all registers to the reset values immediately. Scanning restarts at digit 0 with a full SCAN_DIV period.
- Write latency: data presented at edge N appears on led after edge N. A new seg_val reaches seg_cat at edge N+1 when the affected digit is the lit one.
- Digit change: dig updates at the edge where cnt==SCAN_DIV-1. seg_an and seg_cat follow one edge later, so each digit is lit for exactly SCAN_DIV cycles.
- Exactly one seg_an bit is low at all times after reset; there are no blank gaps between digits.

## Configuration
- BEPU_ZERO_BLANK_EN defined: leading-zero blanking is enabled.
  - Digit k is blanked (seg_cat=8'hFF) when k>0 and every nibble from k up to 7 is 0.
  - Digit 0 is never blanked.
- Not defined: all eight digits always show their hex glyph.

## Structure
- Shared package bepu_pkg holds:
  - the LED_SEL_BIT and SEG_SEL_BIT defaults;
  - SEG_BLANK=8'hFF;
  - the 16-entry hex font constants.
- Sub-module seg7_decode: combinational nibble-plus-blank to cathode lookup.
- The top level holds the write-decode registers, the scan counter and digit index, and the output registers.

## Test plan
- Reset: assert rst=0 mid-run with SCAN_DIV=4. Expect led=0000, seg_an=FE, seg_cat=C0 immediately; after release, the first digit change occurs 4 cycles later.
- LED write: select=32'h2, w=1, data=32'hABCD1234 for 1 cycle. Expect led=16'h1234 next cycle. Repeat with w=0 and data=FFFF; led stays 1234.
- Segment scan: SCAN_DIV=4, write 32'h12345678 to select=32'h4. Over 32 cycles, (seg_an,seg_cat) must step through:
  - (FE,80), (FD,F8), (FB,82), (F7,92)
  - (EF,99), (DF,B0), (BF,A4), (7F,F9)
- Wrap: in the same run, the pair after (7F,F9) is (FE,80). Each digit is held exactly 4 cycles.
- Dual select: select=32'h6, data=32'h0000BEEF. Expect led=BEEF and seg_val=0000BEEF; select=32'h1 write changes neither.
- Blanking: write 32'h00000A05.
  - Macro defined: digits 3..7 show FF; digits 0..2 show 92, C0, 88.
  - Macro undefined: digits 3..7 show C0.
